stopwatch_ctrl: RTL and testbench

//   Upstream control stage for the cascaded BCD timer chain. Debounces three

---
 rtl/stopwatch_ctrl.sv | 143 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control stage: debounces the three push keys and sequences the
// timer chain (count enable, clear pulse, lap-freeze display path).
module stopwatch_ctrl #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int DIGITS     = 3
) (
    input  logic                clk,
    input  logic                aclr,
    input  logic                key_start_n,
    input  logic                key_lap_n,
    input  logic                key_clear_n,
    input  logic                tick,
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic                cnt_en,
    output logic                cnt_clr,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                running,
    output logic                lap_active
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_LAP,
        S_PAUSE
    } state_t;

    // Key vector bit order: 0 = start, 1 = lap, 2 = clear
    logic [2:0]    keys;
    logic [2:0]    sync1_q;
    logic [2:0]    sync2_q;
    logic [2:0]    deb_q;
    logic [2:0]    deb_d;
    logic [2:0]    deb_prev_q;
    logic [2:0]    press_q;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];

    state_t        state_q;
    state_t        state_d;
    logic [W-1:0]  lap_q;
    logic [W-1:0]  lap_d;
    logic          clr_q;
    logic          clr_d;

    logic          ev_start;
    logic          ev_lap;
    logic          ev_clear;

    assign keys = {key_clear_n, key_lap_n, key_start_n};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            sync1_q    <= 3'b111;
            sync2_q    <= 3'b111;
            deb_q      <= 3'b111;
            deb_prev_q <= 3'b111;
            press_q    <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= keys;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            // Press only on the accepted 1->0 edge; release is silent
            press_q    <= deb_prev_q & ~deb_q;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign ev_start = press_q[0];
    assign ev_lap   = press_q[1];
    assign ev_clear = press_q[2];

    // Priority clear > start > lap; a winner the state ignores drops all events
    always_comb begin
        state_d = state_q;
        lap_d   = lap_q;
        clr_d   = 1'b0;
        if (ev_clear) begin
            if (state_q == S_IDLE || state_q == S_PAUSE) begin
                state_d = S_IDLE;
                clr_d   = 1'b1;
            end
        end else if (ev_start) begin
            unique case (state_q)
                S_IDLE:  state_d = S_RUN;
                S_RUN:   state_d = S_PAUSE;
                S_LAP:   state_d = S_PAUSE;
                S_PAUSE: state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end else if (ev_lap) begin
            if (state_q == S_RUN) begin
                state_d = S_LAP;
                lap_d   = bcd_in;
            end else if (state_q == S_LAP) begin
                state_d = S_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            state_q <= S_IDLE;
            lap_q   <= '0;
            clr_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            lap_q   <= lap_d;
            clr_q   <= clr_d;
        end
    end

    assign running    = (state_q == S_RUN) || (state_q == S_LAP);
    assign lap_active = (state_q == S_LAP);
    assign cnt_en     = tick & running;
    assign cnt_clr    = clr_q;
    assign bcd_out    = lap_active ? lap_q : bcd_in;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random
// key activity compared each cycle against a behavioural model.
module tb_stopwatch_ctrl;

    localparam int DEB = 4;
    localparam int DG  = 3;
    localparam int ST_IDLE  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_LAP   = 2;
    localparam int ST_PAUSE = 3;

    logic          clk;
    logic          aclr;
    logic          key_start_n;
    logic          key_lap_n;
    logic          key_clear_n;
    logic          tick;
    logic [4*DG-1:0] bcd_in;
    logic          cnt_en;
    logic          cnt_clr;
    logic [4*DG-1:0] bcd_out;
    logic          running;
    logic          lap_active;

    stopwatch_ctrl #(.DEB_CYCLES(DEB), .DIGITS(DG)) dut (
        .clk         (clk),
        .aclr        (aclr),
        .key_start_n (key_start_n),
        .key_lap_n   (key_lap_n),
        .key_clear_n (key_clear_n),
        .tick        (tick),
        .bcd_in      (bcd_in),
        .cnt_en      (cnt_en),
        .cnt_clr     (cnt_clr),
        .bcd_out     (bcd_out),
        .running     (running),
        .lap_active  (lap_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;
    int clr_hi = 0;

    // Behavioural model: key i flips its accepted level once the synchronised
    // value has disagreed with it for DEB consecutive cycles.
    bit        m_valid = 0;
    bit        m_s1 [3];
    bit        m_s2 [3];
    bit        m_deb [3];
    int        m_agree [3];
    int        m_press_at [3];
    int        m_st;
    logic [11:0] m_lap;
    bit        m_clr;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_update();
        bit raw [3];
        bit ev [3];
        raw[0] = key_start_n;
        raw[1] = key_lap_n;
        raw[2] = key_clear_n;
        if (aclr) begin
            m_valid = 1;
            for (int i = 0; i < 3; i++) begin
                m_s1[i] = 1; m_s2[i] = 1; m_deb[i] = 1;
                m_agree[i] = cyc; m_press_at[i] = -1;
            end
            m_st = ST_IDLE; m_lap = '0; m_clr = 1;
        end else if (m_valid) begin
            for (int i = 0; i < 3; i++) begin
                ev[i] = (m_press_at[i] == cyc);
                if (m_s2[i] != m_deb[i]) begin
                    if (cyc - m_agree[i] >= DEB) begin
                        m_deb[i] = m_s2[i];
                        m_agree[i] = cyc;
                        if (!m_deb[i]) m_press_at[i] = cyc + 2;
                    end
                end else begin
                    m_agree[i] = cyc;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = raw[i];
            end
            m_clr = 0;
            if (ev[2]) begin
                if (m_st == ST_IDLE || m_st == ST_PAUSE) begin
                    m_st = ST_IDLE; m_clr = 1;
                end
            end else if (ev[0]) begin
                m_st = (m_st == ST_IDLE || m_st == ST_PAUSE) ? ST_RUN : ST_PAUSE;
            end else if (ev[1]) begin
                if (m_st == ST_RUN) begin
                    m_st = ST_LAP; m_lap = bcd_in;
                end else if (m_st == ST_LAP) begin
                    m_st = ST_RUN;
                end
            end
        end
    endtask

    task automatic step();
        bit run_e;
        #1;
        if (m_valid) begin
            run_e = (m_st == ST_RUN) || (m_st == ST_LAP);
            chk("cnt_en", 32'(cnt_en), 32'(tick & run_e));
            chk("cnt_clr", 32'(cnt_clr), 32'(m_clr));
            chk("running", 32'(running), 32'(run_e));
            chk("lap_active", 32'(lap_active), 32'(m_st == ST_LAP));
            chk("bcd_out", 32'(bcd_out),
                32'((m_st == ST_LAP) ? m_lap : bcd_in));
        end
        if (cnt_clr === 1'b1) clr_hi++;
        model_update();
        @(negedge clk);
        cyc++;
        tick = (cyc % 5 == 4);
    endtask

    task automatic set_keys(input logic [2:0] low_mask);
        key_start_n = ~low_mask[0];
        key_lap_n   = ~low_mask[1];
        key_clear_n = ~low_mask[2];
    endtask

    task automatic hold(input logic [2:0] low_mask, input int n);
        for (int k = 0; k < n; k++) begin
            set_keys(low_mask);
            step();
        end
        set_keys(3'b000);
    endtask

    task automatic press(input logic [2:0] low_mask);
        hold(low_mask, 6);
        hold(3'b000, 12);
    endtask

    int c0;
    int hl [3];
    bit hv [3];

    initial begin
        aclr = 1'b1; tick = 1'b0; bcd_in = '0;
        set_keys(3'b000);
        @(negedge clk);
        cyc = 0;
        step();
        chk("clr_in_reset", 32'(cnt_clr), 32'd1);
        step();
        aclr = 1'b0;
        step();
        step();
        chk("clr_after_reset", 32'(cnt_clr), 32'd0);
        chk("idle_after_reset", 32'(running), 32'd0);
        hold(3'b000, 8);

        // Held start key: press pulse in cycle 7, RUN visible in cycle 8
        for (int k = 0; k < 10; k++) begin
            set_keys(3'b001);
            if (k == 7) chk("run_not_yet_c7", 32'(running), 32'd0);
            if (k == 8) chk("run_at_c8", 32'(running), 32'd1);
            step();
        end
        hold(3'b000, 12);
        chk("one_event_per_hold", 32'(running), 32'd1);
        hold(3'b001, 3);
        hold(3'b000, 12);
        chk("bounce_ignored", 32'(running), 32'd1);

        bcd_in = 12'h042;
        press(3'b010);
        bcd_in = 12'h057;
        #1;
        chk("lap_active", 32'(lap_active), 32'd1);
        chk("lap_frozen", 32'(bcd_out), 32'h042);
        press(3'b010);
        bcd_in = 12'h123;
        #1;
        chk("lap_released", 32'(bcd_out), 32'h123);

        c0 = clr_hi;
        press(3'b100);
        chk("clear_ignored_run", 32'(clr_hi - c0), 32'd0);
        chk("still_running", 32'(running), 32'd1);
        press(3'b001);
        chk("paused", 32'(running), 32'd0);
        c0 = clr_hi;
        press(3'b100);
        chk("clear_pulse_len", 32'(clr_hi - c0), 32'd1);

        press(3'b001);
        press(3'b011);
        chk("start_beats_lap", 32'(running), 32'd0);
        chk("no_lap_on_tie", 32'(lap_active), 32'd0);
        c0 = clr_hi;
        press(3'b101);
        chk("clear_beats_start", 32'(running), 32'd0);
        chk("tie_clear_pulse", 32'(clr_hi - c0), 32'd1);

        press(3'b001);
        press(3'b010);
        chk("in_lap", 32'(lap_active), 32'd1);
        bcd_in = 12'h321;
        aclr = 1'b1;
        step();
        aclr = 1'b0;
        #1;
        chk("reset_from_lap_run", 32'(running), 32'd0);
        chk("reset_from_lap_clr", 32'(cnt_clr), 32'd1);
        chk("reset_from_lap_bcd", 32'(bcd_out), 32'h321);
        hold(3'b000, 10);

        for (int i = 0; i < 3; i++) begin
            hl[i] = 0; hv[i] = 1;
        end
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (hl[i] == 0) begin
                    hv[i] = ($urandom_range(0, 9) < 6);
                    hl[i] = $urandom_range(1, 9);
                end
                hl[i]--;
            end
            key_start_n = hv[0];
            key_lap_n   = hv[1];
            key_clear_n = hv[2];
            aclr   = ($urandom_range(0, 499) == 0);
            bcd_in = 12'($urandom);
            step();
        end
        aclr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
